// File: rtl/sprite_compositor.sv
// Four-layer sprite/background compositor for the VGA path, plus per-frame player/hazard overlap detection.
// Define SPRITE_COMPOSITOR_COLLIDE_EN to build the hit register and the coll_req/coll_ack handshake.
module sprite_compositor #(
  parameter int unsigned H_LAST    = 639,
  parameter int unsigned V_LAST    = 479,
  parameter logic [11:0] KEY_COLOR = 12'h000,
  parameter logic [15:0] BG_KEY    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [1:0]  game_state,
  input  logic [39:0] spr_x,
  input  logic [35:0] spr_y,
  input  logic [27:0] spr_w,
  input  logic [27:0] spr_h,
  input  logic [47:0] spr_color,
  input  logic [15:0] bg_color,
  output logic [11:0] vga_data,
  output logic        coll_req,
  input  logic        coll_ack,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    GS_INITIAL = 2'b00,
    GS_RUNNING = 2'b01,
    GS_OVER    = 2'b10,
    GS_SUCCESS = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    SYNC,
    SCAN,
    LATCH
  } frame_state_t;

  game_state_t  gs;
  frame_state_t state, state_d;

  logic [9:0]  rel_x [4];
  logic [8:0]  rel_y [4];
  logic [3:0]  inbox_d, inbox, opaque;
  logic [9:0]  x1;
  logic [8:0]  y1;
  logic        s1_valid;
  logic [11:0] pix_d;
  logic        at_origin, at_end;

  assign gs = game_state_t'(game_state);

  // Modulo subtraction: a pixel left of / above the sprite wraps to a large offset and fails the size compare.
  always_comb begin
    inbox_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rel_x[i]   = x - spr_x[10*i +: 10];
      rel_y[i]   = y - spr_y[9*i +: 9];
      inbox_d[i] = (rel_x[i] < {3'b000, spr_w[7*i +: 7]}) &
                   (rel_y[i] < {2'b00, spr_h[7*i +: 7]});
    end
  end

  always_comb begin
    opaque = '0;
    for (int unsigned i = 0; i < 4; i++)
      opaque[i] = inbox[i] & (spr_color[12*i +: 12] != KEY_COLOR);
  end

  always_comb begin
    pix_d = '0;
    case (gs)
      GS_INITIAL: pix_d = 12'hF00;
      GS_RUNNING: begin
        if (opaque[0])             pix_d = spr_color[11:0];
        else if (opaque[1])        pix_d = spr_color[23:12];
        else if (opaque[2])        pix_d = spr_color[35:24];
        else if (opaque[3])        pix_d = spr_color[47:36];
        else if (bg_color == BG_KEY) pix_d = 12'h000;
        else                       pix_d = bg_color[15:4];
      end
      GS_OVER:    pix_d = bg_color[15:4];
      default:    pix_d = 12'h00F;
    endcase
  end

  // s1_valid keeps the zeroed post-reset S1 position from being mistaken for a real (0,0) frame start.
  assign at_origin = s1_valid && (x1 == 10'd0) && (y1 == 9'd0);
  assign at_end    = s1_valid && (x1 == 10'(H_LAST)) && (y1 == 9'(V_LAST));

  always_comb begin
    state_d = state;
    case (state)
      SYNC:    if (pix_en && at_origin) state_d = SCAN;
      SCAN:    if (pix_en && at_end)    state_d = LATCH;
      LATCH:   state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SYNC;
      inbox     <= '0;
      x1        <= '0;
      y1        <= '0;
      s1_valid  <= 1'b0;
      vga_data  <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == LATCH)
        frame_cnt <= frame_cnt + 8'd1;
      if (pix_en) begin
        inbox    <= inbox_d;
        x1       <= x;
        y1       <= y;
        s1_valid <= 1'b1;
        vga_data <= pix_d;
      end
    end
  end

`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  logic hit, hit_d;

  always_comb begin
    hit_d = hit;
    if (state == SYNC && pix_en && at_origin)
      hit_d = 1'b0;
    else if (state == SCAN && pix_en && gs == GS_RUNNING && opaque[0] && opaque[3])
      hit_d = 1'b1;
  end

  // A latch with hit outranks a simultaneous ack so a fresh event is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit      <= 1'b0;
      coll_req <= 1'b0;
    end else begin
      hit <= hit_d;
      if (state == LATCH && hit)
        coll_req <= 1'b1;
      else if (coll_ack)
        coll_req <= 1'b0;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = coll_ack;
  assign coll_req   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed pixels and short frames, checks queued by cycle and
// compared by an independent monitor process.
module tb_sprite_compositor;

  localparam int V_LAST_TB = 7;
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pix_en, coll_ack, coll_req;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [1:0]  game_state;
  logic [15:0] bg_color;
  logic [11:0] vga_data;
  logic [7:0]  frame_cnt;
  logic [9:0]  lx [4];
  logic [8:0]  ly [4];
  logic [6:0]  lw [4];
  logic [6:0]  lh [4];
  logic [11:0] lc [4];
  logic [39:0] spr_x;
  logic [35:0] spr_y;
  logic [27:0] spr_w, spr_h;
  logic [47:0] spr_color;

  assign spr_x     = {lx[3], lx[2], lx[1], lx[0]};
  assign spr_y     = {ly[3], ly[2], ly[1], ly[0]};
  assign spr_w     = {lw[3], lw[2], lw[1], lw[0]};
  assign spr_h     = {lh[3], lh[2], lh[1], lh[0]};
  assign spr_color = {lc[3], lc[2], lc[1], lc[0]};

  sprite_compositor #(.V_LAST(V_LAST_TB)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .game_state(game_state),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_color(spr_color),
    .bg_color(bg_color), .vga_data(vga_data), .coll_req(coll_req), .coll_ack(coll_ack),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 vga_data, 1 coll_req, 2 frame_cnt
  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc  = 0;
  int   nchk = 0;
  int   nerr = 0;

  task automatic push(input int c, input int k, input logic [11:0] e, input string n);
    chk_t t;
    t.cyc = c; t.kind = k; t.exp = e; t.name = n;
    q.push_back(t);
  endtask

  initial begin : monitor
    chk_t        t;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        t = q.pop_front();
        nchk++;
        if (t.cyc < cyc) begin
          nerr++;
          $display("FAIL %s: slot %0d passed without a sample (now %0d)", t.name, t.cyc, cyc);
        end else begin
          case (t.kind)
            0:       act = vga_data;
            1:       act = {11'b0, coll_req};
            default: act = {4'b0, frame_cnt};
          endcase
          if (act !== t.exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", t.name, act, t.exp, cyc);
          end
        end
      end
    end
  end

  task automatic set_layer(input int i, input logic [9:0] px, input logic [8:0] py,
                           input logic [6:0] w, input logic [6:0] h, input logic [11:0] c);
    lx[i] = px; ly[i] = py; lw[i] = w; lh[i] = h; lc[i] = c;
  endtask

  // Present a pixel on two strobes with a gap; check the output after the second strobe and while held.
  task automatic show(input logic [9:0] px, input logic [8:0] py, input logic [11:0] e, input string n);
    int c0;
    c0 = cyc;
    push(c0 + 3, 0, e, n);
    push(c0 + 4, 0, e, {n, "_hold"});
    x = px; y = py; pix_en = 1'b1;
    @(negedge clk); pix_en = 1'b0;
    @(negedge clk); pix_en = 1'b1;
    @(negedge clk); pix_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int rst_row, input bit ack_latch,
                           input logic c_prev, input logic [7:0] f_prev,
                           input logic c_new, input logic [7:0] f_new, input string n);
    int c;
    for (int r = 0; r <= V_LAST_TB; r++) begin
      for (int col = 0; col <= 639; col++) begin
        if (r == rst_row && col == 0) begin
          rst = 1'b0; pix_en = 1'b0; c = cyc;
          push(c + 1, 0, 12'h000, {n, "_rst_vga"});
          push(c + 1, 1, 12'h000, {n, "_rst_coll"});
          push(c + 1, 2, 12'h000, {n, "_rst_fc"});
          @(negedge clk); @(negedge clk);
          rst = 1'b1;
        end
        x = 10'(col); y = 9'(r); pix_en = 1'b1;
        @(negedge clk);
      end
    end
    x = 10'd640; y = 9'(V_LAST_TB); pix_en = 1'b1; c = cyc;
    push(c + 1, 1, {11'b0, COLL_EN & c_prev}, {n, "_coll_pre"});
    push(c + 1, 2, {4'b0, f_prev},            {n, "_fc_pre"});
    push(c + 2, 1, {11'b0, COLL_EN & c_new},  {n, "_coll"});
    push(c + 2, 2, {4'b0, f_new},             {n, "_fc"});
    push(c + 4, 1, {11'b0, COLL_EN & c_new},  {n, "_coll_hold"});
    @(negedge clk); pix_en = 1'b0; coll_ack = ack_latch;
    @(negedge clk); coll_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack_pulse(input string n);
    int c;
    c = cyc;
    push(c + 1, 1, 12'h000, n);
    push(c + 2, 1, 12'h000, {n, "_hold"});
    coll_ack = 1'b1;
    @(negedge clk); coll_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_check(input logic c_exp, input string n);
    int c;
    c = cyc;
    push(c + 5, 1, {11'b0, COLL_EN & c_exp}, n);
    repeat (5) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    rst = 1'b0; pix_en = 1'b0; coll_ack = 1'b0; x = '0; y = '0;
    game_state = 2'b00; bg_color = 16'hABCD;
    set_layer(0, 10'd100, 9'd100, 7'd34, 7'd36, 12'h0F0);
    set_layer(1, 10'd630, 9'd5,   7'd20, 7'd10, 12'h0A5);
    set_layer(2, 10'd1000, 9'd500, 7'd1, 7'd1,  12'h555);
    set_layer(3, 10'd105, 9'd105, 7'd20, 7'd20, 12'h00F);
    @(negedge clk); @(negedge clk);

    c = cyc;
    for (int k = 1; k <= 3; k++) begin
      push(c + k, 0, 12'h000, "reset_vga");
      push(c + k, 1, 12'h000, "reset_coll");
      push(c + k, 2, 12'h000, "reset_fc");
    end
    repeat (3) begin
      x = 10'($urandom); y = 9'($urandom); pix_en = 1'($urandom);
      coll_ack = 1'($urandom); game_state = 2'($urandom); bg_color = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b1; pix_en = 1'b0; coll_ack = 1'b0; game_state = 2'b00; bg_color = 16'hABCD;

    show(10'd3, 9'd3, 12'hF00, "initial");
    game_state = 2'b01;
    show(10'd110, 9'd110, 12'h0F0, "prio_l0_over_l3");
    lc[0] = 12'h000;
    show(10'd110, 9'd110, 12'h00F, "prio_l0_keyed");
    lc[0] = 12'h0F0;
    show(10'd133, 9'd100, 12'h0F0, "l0_right_edge_in");
    show(10'd134, 9'd100, 12'hABC, "l0_right_edge_out");
    show(10'd100, 9'd136, 12'hABC, "l0_bottom_edge_out");
    bg_color = 16'hFFFF;
    show(10'd5, 9'd5, 12'h000, "bg_keyed");
    bg_color = 16'hABCD;
    show(10'd5, 9'd5, 12'hABC, "bg_plain");
    show(10'd639, 9'd6, 12'h0A5, "wrap_x639_in");
    show(10'd0, 9'd6, 12'hABC, "wrap_x0_out");
    game_state = 2'b10;
    show(10'd110, 9'd110, 12'hABC, "over_bg");
    bg_color = 16'hFFFF;
    show(10'd110, 9'd110, 12'hFFF, "over_no_key");
    bg_color = 16'hABCD;
    game_state = 2'b11;
    show(10'd50, 9'd50, 12'h00F, "success");

    game_state = 2'b01;
    set_layer(0, 10'd200, 9'd2, 7'd10, 7'd2, 12'h0F0);
    set_layer(3, 10'd205, 9'd2, 7'd10, 7'd2, 12'h00F);
    run_frame(-1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1, "f1_hit");
    idle_check(1'b1, "f1_no_ack_hold");
    ack_pulse("f1_ack");
    run_frame(-1, 1'b0, 1'b0, 8'd1, 1'b1, 8'd2, "f2_hit");
    run_frame(-1, 1'b1, 1'b1, 8'd2, 1'b1, 8'd3, "f3_ack_vs_latch");
    ack_pulse("f3_ack");
    game_state = 2'b10;
    run_frame(-1, 1'b0, 1'b0, 8'd3, 1'b0, 8'd4, "f4_over_no_hit");
    game_state = 2'b01;
    run_frame(5, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, "f5_mid_reset");
    run_frame(-1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1, "f6_after_reset");

    repeat (10) @(negedge clk);
    if (q.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL pending: %0d checks never reached, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Per-pixel layer controller for the VGA path. It arbitrates four sprite layers plus the background into the single 12-bit `vga_data` stream, with fixed priority, colour-key transparency and a game-state override. It also detects per-frame player/hazard overlap and hands the result to the game FSM over a req/ack handshake. It sits between the sprite colour generators and `VGA_driver`, replacing ad-hoc priority muxing in the top level.

## Interface
Parameters:
- `H_LAST`, default 639: last active x.
- `V_LAST`, default 479: last active y.
- `KEY_COLOR`, default 12'h000: sprite colour treated as transparent.
- `BG_KEY`, default 16'hFFFF: background value remapped to black.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `pix_en` in 1: pixel strobe, one `clk` wide; the pipeline advances only on it.
- `x` in 10, `y` in 9: current scan position from the VGA driver.
- `game_state` in 2: 00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS.
- `spr_x` in 40 / `spr_y` in 36: layer i top-left corner at bits [10i+9:10i] and [9i+8:9i].
- `spr_w` / `spr_h` in 28 each: layer i size at [7i+6:7i], range 1..127.
- `spr_color` in 48: layer i colour at [12i+11:12i], valid one `pix_en` after the matching `x`/`y`.
- `bg_color` in 16: background RGB at [15:4], same alignment as `spr_color`.
- `vga_data` out 12: composed pixel.
- `coll_req` out 1: collision pending.
- `coll_ack` in 1: collision consumed.
- `frame_cnt` out 8: completed frames, wrapping.

## Operation
Pipeline (each stage advances on `pix_en` only):
- **S1:** compute `rel_x = x - spr_x[i]` (10-bit unsigned, modulo) and `rel_y = y - spr_y[i]` (9-bit unsigned). Register `inbox[i] = (rel_x < w_i) & (rel_y < h_i)` and register `x`/`y`. Wrap-around makes a pixel left of or above the sprite compare large, so it is outside the box.
- **S2:** `opaque[i] = inbox[i] & (spr_color[i] != KEY_COLOR)`. Select by `game_state`:
  - INITIAL → 12'hF00.
  - RUNNING → `spr_color` of the lowest-index opaque layer (layer 0 has highest priority). If no layer is opaque: `bg_color == BG_KEY` gives 12'h000, otherwise `bg_color[15:4]`.
  - OVER → `bg_color[15:4]`.
  - SUCCESS → 12'h00F.
  - The result is registered into `vga_data`.

Frame FSM, with states SYNC, SCAN and LATCH:
- **SYNC:** wait for S1 position (0,0) on `pix_en`, then go to SCAN and clear `hit`.
- **SCAN:** on each `pix_en`, if `game_state == RUNNING` and `opaque[0] & opaque[3]`, set sticky `hit`. When S1 position equals (`H_LAST`, `V_LAST`), go to LATCH.
- **LATCH:** lasts one `clk`. Increment `frame_cnt`, set `coll_req` if `hit`, return to SYNC.

`coll_req` handshake:
- Stays high until `coll_ack` is sampled high; it clears on the next edge.
- If LATCH with `hit` coincides with `coll_ack`, `coll_req` stays high (the new event wins).
- Only one request is outstanding at a time; further hits are merged while `coll_req` is high.

Reset behaviour:
- Reset mid-frame forces SYNC. The partially scanned frame produces no latch and no `frame_cnt` increment.
- A `game_state` change mid-frame takes effect at S2 on the next `pix_en`.

## Timing
- Reset values: `vga_data` = 12'h000, `coll_req` = 0, `frame_cnt` = 0, FSM = SYNC, all pipeline registers 0.
- Latency: `vga_data` for position (x,y) is valid 2 `pix_en` strobes after (x,y) is presented, and is held between strobes.
- `coll_req` rises 1 `clk` after the `pix_en` that scans (`H_LAST`, `V_LAST`).
- `frame_cnt` increments in that same cycle and wraps 255→0.
- With `pix_en` low, every register except the handshake and FSM LATCH exit holds its value.

## Configuration
- `SPRITE_COMPOSITOR_COLLIDE_EN` defined: the `hit` logic and `coll_req` handshake are built as described above.
- Not defined: `coll_req` is tied to 0, `coll_ack` is ignored, and no `hit` register exists. The frame FSM and `frame_cnt` are unchanged.

## Test plan
1. **Reset:** hold `rst`=0 for 3 clk with random inputs → `vga_data`=000, `coll_req`=0, `frame_cnt`=0. Release, then 2 strobes with INITIAL → `vga_data`=F00.
2. **Priority:** RUNNING; layer0 at (100,100) 34×36 colour 0F0; layer3 overlapping colour 00F; pixel (110,110) → 0F0. Set layer0 colour = KEY_COLOR → 00F.
3. **Background key:** RUNNING, no sprite at (5,5), `bg_color`=FFFF → 000. `bg_color`=ABCD → ABC.
4. **Wrap boundary:** layer1 at x=630, w=20. Pixel x=639 → inside. Pixel x=0 → `rel_x` = 394, which is ≥ w, so outside (no wrap-around drawing).
5. **Collision handshake:** layers 0 and 3 overlap during one full frame → `coll_req`=1 one clk after (639,479). Hold `coll_ack`=0 → stays 1. Pulse ack → 0 next clk. Ack coinciding with a new latch → remains 1.
6. **Mid-frame reset:** assert `rst` at y=200 with overlap → no `coll_req`, `frame_cnt` unchanged. Next full frame latches normally.
